// File: rtl/clockdiv_frac_if.sv
// Control/status bundle for clockdiv_frac: channel enables, increment write port, per-channel outputs.
// master: channel enables and increment writes out, pending/divided-clock/pulse status in.
// slave:  the generator's view of the same signals, with the directions reversed.
interface clockdiv_frac_if #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 24
);
  localparam int WR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] ch_en;
  logic              wr_en;
  logic [WR_W-1:0]   wr_ch;
  logic [ACC_W-1:0]  wr_inc;
  logic [NUM_CH-1:0] inc_pend;
  logic [NUM_CH-1:0] clk_div;
  logic [NUM_CH-1:0] ce;

  modport master (output ch_en, wr_en, wr_ch, wr_inc, input inc_pend, clk_div, ce);
  modport slave  (input ch_en, wr_en, wr_ch, wr_inc, output inc_pend, clk_div, ce);
endinterface

// File: rtl/clockdiv_frac.sv
// Multi-channel fractional clock generator built from phase accumulators.
// Latency: registered outputs that reflect the addition made on the same edge (ch_en high at edge 0 -> first add at edge 0).
// Backpressure: none. Writes are always accepted, and rate changes wait for a wrap or a stopped channel.
// Ports: clk_src / reset_n (sync, active-low) plus bus (slave): ch_en, wr_en/wr_ch/wr_inc in;
//        inc_pend, clk_div (accumulator MSB), ce (one pulse per wrap) out.
module clockdiv_frac #(
  parameter int          NUM_CH  = 4,
  parameter int          ACC_W   = 24,
  parameter int unsigned INC_RST = 480437
) (
  input  logic           clk_src,
  input  logic           reset_n,
  clockdiv_frac_if.slave bus
);
  localparam int WR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // Largest legal increment (half scale). It gives a clk_src/2 output.
  localparam logic [ACC_W-1:0] HALF = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [ACC_W-1:0]  acc_d [NUM_CH];
  logic [ACC_W-1:0]  inc_q [NUM_CH];
  logic [ACC_W-1:0]  inc_d [NUM_CH];
  logic [ACC_W-1:0]  shd_q [NUM_CH];
  logic [ACC_W-1:0]  shd_d [NUM_CH];
  logic [ACC_W:0]    sum   [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] div_q, div_d;
  logic [NUM_CH-1:0] ce_q, ce_d;
  logic [ACC_W-1:0]  wr_clamped;

  assign wr_clamped = (bus.wr_inc > HALF) ? HALF : bus.wr_inc;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_sum
    assign sum[g] = {1'b0, acc_q[g]} + {1'b0, inc_q[g]};
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      acc_d[i]  = '0;
      inc_d[i]  = inc_q[i];
      shd_d[i]  = shd_q[i];
      pend_d[i] = pend_q[i];
      div_d[i]  = 1'b0;
      ce_d[i]   = 1'b0;

      // A stopped channel is held at phase zero, so channels enabled together stay aligned.
      if (bus.ch_en[i]) begin
        acc_d[i] = sum[i][ACC_W-1:0];
        ce_d[i]  = sum[i][ACC_W];
        div_d[i] = sum[i][ACC_W-1];
      end

      // Swap the rate only at a period boundary (or while idle) so no runt pulse appears.
      if (pend_q[i] && (!bus.ch_en[i] || sum[i][ACC_W])) begin
        inc_d[i]  = shd_q[i];
        pend_d[i] = 1'b0;
      end

      // A write on the apply edge wins the pending flag. The value it displaces has already been applied.
      if (bus.wr_en && (bus.wr_ch == WR_W'(i))) begin
        shd_d[i]  = wr_clamped;
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_src) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        inc_q[i] <= ACC_W'(INC_RST);
        shd_q[i] <= ACC_W'(INC_RST);
      end
      pend_q <= '0;
      div_q  <= '0;
      ce_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= acc_d[i];
        inc_q[i] <= inc_d[i];
        shd_q[i] <= shd_d[i];
      end
      pend_q <= pend_d;
      div_q  <= div_d;
      ce_q   <= ce_d;
    end
  end

  assign bus.inc_pend = pend_q;
  assign bus.clk_div  = div_q;
  assign bus.ce       = ce_q;
endmodule

// File: tb/tb_clockdiv_frac.sv
// Bench for clockdiv_frac at ACC_W=8 with three channels. A wr_ch value of 3 is out of range for this configuration.
// Every edge is compared against a plain-arithmetic reference model, and scenario checks are layered on top.
module tb_clockdiv_frac;
  localparam int NCH  = 3;
  localparam int AW   = 8;
  localparam int INC0 = 20;
  localparam int FULL = 1 << AW;
  localparam int HALF = 1 << (AW - 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clockdiv_frac_if #(.NUM_CH(NCH), .ACC_W(AW)) bus ();
  clockdiv_frac #(.NUM_CH(NCH), .ACC_W(AW), .INC_RST(INC0)) dut (
    .clk_src(clk), .reset_n(rst_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: phase held as a plain integer in 0..FULL-1.
  int m_acc [NCH];
  int m_inc [NCH];
  int m_shd [NCH];
  bit m_pend[NCH];
  bit m_div [NCH];
  bit m_ce  [NCH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      bit en;
      bit wrap;
      int s;
      if (!rst_n) begin
        m_acc[c] = 0; m_inc[c] = INC0; m_shd[c] = INC0;
        m_pend[c] = 0; m_div[c] = 0; m_ce[c] = 0;
      end else begin
        en = bus.ch_en[c];
        wrap = 0;
        if (en) begin
          s = m_acc[c] + m_inc[c];
          wrap = (s >= FULL);
          m_acc[c] = s % FULL;
          m_ce[c] = wrap;
          m_div[c] = (m_acc[c] >= HALF);
        end else begin
          m_acc[c] = 0; m_ce[c] = 0; m_div[c] = 0;
        end
        if (m_pend[c] && (wrap || !en)) begin
          m_inc[c] = m_shd[c];
          m_pend[c] = 0;
        end
        if (bus.wr_en && int'(bus.wr_ch) == c) begin
          m_shd[c] = (int'(bus.wr_inc) > HALF) ? HALF : int'(bus.wr_inc);
          m_pend[c] = 1;
        end
      end
    end
  endtask

  task automatic tick();
    logic [NCH-1:0] ep, ed, ec;
    model_step();
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      ep[c] = m_pend[c]; ed[c] = m_div[c]; ec[c] = m_ce[c];
    end
    chk("model_inc_pend", 32'(bus.inc_pend), 32'(ep));
    chk("model_clk_div", 32'(bus.clk_div), 32'(ed));
    chk("model_ce", 32'(bus.ce), 32'(ec));
  endtask

  task automatic wr(input int c, input int v);
    bus.wr_en = 1'b1;
    bus.wr_ch = 2'(c);
    bus.wr_inc = 8'(v);
    tick();
    bus.wr_en = 1'b0;
  endtask

  // Number of edges until the next ce on channel c, or -1 if none arrives within the budget.
  task automatic gap_to_ce(input int c, output int n);
    n = -1;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (bus.ce[c]) begin
        n = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [2:0] ch_en;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_inc;
    logic [2:0] e_pend;
    logic [2:0] e_div;
    logic [2:0] e_ce;
  } vec_t;

  initial begin
    vec_t tbl[8];
    int n, cnt, rises, bad_gap, last_ce;
    int ce_cnt[NCH];
    logic prev_div;

    // Vectors 0-1 load inc=64 into ch0 while stopped. Vectors 2-7 run ch0: clk_div 0,1,1,0 and ce on the 4th edge.
    tbl[0] = '{3'b000, 1'b1, 2'd0, 8'd64, 3'b001, 3'b000, 3'b000};
    tbl[1] = '{3'b000, 1'b0, 2'd0, 8'd0,  3'b000, 3'b000, 3'b000};
    tbl[2] = '{3'b001, 1'b0, 2'd0, 8'd0,  3'b000, 3'b000, 3'b000};
    tbl[3] = '{3'b001, 1'b0, 2'd0, 8'd0,  3'b000, 3'b001, 3'b000};
    tbl[4] = '{3'b001, 1'b0, 2'd0, 8'd0,  3'b000, 3'b001, 3'b000};
    tbl[5] = '{3'b001, 1'b0, 2'd0, 8'd0,  3'b000, 3'b000, 3'b001};
    tbl[6] = '{3'b001, 1'b0, 2'd0, 8'd0,  3'b000, 3'b000, 3'b000};
    tbl[7] = '{3'b001, 1'b0, 2'd0, 8'd0,  3'b000, 3'b001, 3'b000};

    bus.ch_en = '1; bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_inc = '0;

    // Hold reset for 3 edges with every channel enabled.
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("rst_clk_div", 32'(bus.clk_div), 0);
    chk("rst_ce", 32'(bus.ce), 0);
    chk("rst_inc_pend", 32'(bus.inc_pend), 0);

    // After release, the reset increment gives exactly INC0 wraps per 256 edges.
    rst_n = 1'b1;
    for (int c = 0; c < NCH; c++) ce_cnt[c] = 0;
    for (int k = 0; k < FULL; k++) begin
      tick();
      for (int c = 0; c < NCH; c++) if (bus.ce[c]) ce_cnt[c]++;
    end
    for (int c = 0; c < NCH; c++) chk("inc_rst_rate", ce_cnt[c], INC0);

    // Table-driven integer-rate sequence, starting from a clean reset with all channels stopped.
    rst_n = 1'b0; bus.ch_en = '0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.ch_en = tbl[i].ch_en; bus.wr_en = tbl[i].wr_en;
      bus.wr_ch = tbl[i].wr_ch; bus.wr_inc = tbl[i].wr_inc;
      tick();
      chk("tbl_inc_pend", 32'(bus.inc_pend), 32'(tbl[i].e_pend));
      chk("tbl_clk_div", 32'(bus.clk_div), 32'(tbl[i].e_div));
      chk("tbl_ce", 32'(bus.ce), 32'(tbl[i].e_ce));
    end
    bus.wr_en = 1'b0;

    // Glitch-free update: ch0 is at acc=128, inc=64. A mid-period write to 32 waits for the wrap.
    wr(0, 32);
    chk("glitch_pend_set", 32'(bus.inc_pend[0]), 1);
    gap_to_ce(0, n);
    chk("glitch_old_rate_gap", n, 1);
    chk("glitch_pend_clr", 32'(bus.inc_pend[0]), 0);
    gap_to_ce(0, n);
    chk("glitch_new_period", n, 8);

    // A write on the exact wrap edge applies one wrap later.
    for (int k = 0; k < 7; k++) tick();
    wr(0, 64);
    chk("wrap_edge_ce", 32'(bus.ce[0]), 1);
    chk("wrap_edge_pend", 32'(bus.inc_pend[0]), 1);
    gap_to_ce(0, n);
    chk("wrap_write_old_rate", n, 8);
    gap_to_ce(0, n);
    chk("wrap_write_new_rate", n, 4);

    // A write that coincides with an apply: the apply uses the earlier shadow value (16), and 32 follows one wrap later.
    tick();
    wr(0, 16);
    tick();
    wr(0, 32);
    chk("coincide_ce", 32'(bus.ce[0]), 1);
    chk("coincide_pend", 32'(bus.inc_pend[0]), 1);
    gap_to_ce(0, n);
    chk("coincide_pre_write", n, 16);
    gap_to_ce(0, n);
    chk("coincide_post_write", n, 8);

    // Alignment: stop both channels, apply while stopped, then restart them together.
    bus.ch_en = 3'b011;
    for (int k = 0; k < 10; k++) tick();
    wr(1, 32);
    bus.ch_en = 3'b000;
    tick();
    chk("stop_apply", 32'(bus.inc_pend[1]), 0);
    bus.ch_en = 3'b011;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("align_div", 32'(bus.clk_div[1]), 32'(bus.clk_div[0]));
      chk("align_ce", 32'(bus.ce[1]), 32'(bus.ce[0]));
    end

    // Fractional rate: inc=96 gives 96 wraps in 256 edges, spacing 2 or 3, and 96 rising edges.
    bus.ch_en = 3'b000;
    wr(0, 96);
    tick();
    bus.ch_en = 3'b001;
    cnt = 0; rises = 0; bad_gap = 0; last_ce = -1; prev_div = 1'b0;
    for (int k = 0; k < FULL; k++) begin
      tick();
      if (bus.ce[0]) begin
        cnt++;
        if (last_ce >= 0 && (k - last_ce < 2 || k - last_ce > 3)) bad_gap++;
        last_ce = k;
      end
      if (bus.clk_div[0] && !prev_div) rises++;
      prev_div = bus.clk_div[0];
    end
    chk("frac_ce_count", cnt, 96);
    chk("frac_bad_gaps", bad_gap, 0);
    chk("frac_rises", rises, 96);

    // Clamp: 0xFF is stored as 128, so clk_div toggles every edge and ce fires every other edge.
    bus.ch_en = 3'b000;
    wr(2, 8'hFF);
    tick();
    bus.ch_en = 3'b100;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("clamp_div", 32'(bus.clk_div[2]), (k % 2 == 0) ? 1 : 0);
      chk("clamp_ce", 32'(bus.ce[2]), (k % 2 == 1) ? 1 : 0);
    end

    // An out-of-range channel write changes nothing.
    wr(3, 5);
    chk("bad_ch_ignored", 32'(bus.inc_pend), 0);

    // Reset asserted while a ce pulse is high clears every output on the next edge.
    n = 0;
    for (int k = 0; k < 4 && !bus.ce[2]; k++) tick();
    chk("midpulse_ce_seen", 32'(bus.ce[2]), 1);
    rst_n = 1'b0;
    tick();
    chk("midpulse_rst_div", 32'(bus.clk_div), 0);
    chk("midpulse_rst_ce", 32'(bus.ce), 0);
    chk("midpulse_rst_pend", 32'(bus.inc_pend), 0);
    rst_n = 1'b1;

    // Randomized traffic checked against the model on every edge.
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int c = 0; c < NCH; c++) bus.ch_en[c] = ($urandom_range(0, 99) < 85);
      bus.wr_en = ($urandom_range(0, 7) == 0);
      bus.wr_ch = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: bus.wr_inc = 8'($urandom_range(0, 8));
        1: bus.wr_inc = 8'($urandom_range(120, 255));
        default: bus.wr_inc = 8'($urandom_range(0, 128));
      endcase
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
